// File: rtl/gsim_pkg.sv
// Shared definitions for the gsim host: state encoding, buffer geometry and word widths.
package gsim_pkg;

    localparam int N_WORDS = 16;
    localparam int B_W     = 16;
    localparam int X_W     = 32;
    localparam int CNT_W   = $clog2(N_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_COLLECT,
        ST_DONE
    } state_e;

    function automatic logic is_last(input logic [CNT_W-1:0] c);
        return c == CNT_W'(N_WORDS - 1);
    endfunction

endpackage

// File: rtl/gsim_host_fsm.sv
// Sequencer for the gsim host: state register, word counter and (with GSIM_HOST_TIMEOUT_EN) the WAIT timeout.
module gsim_host_fsm
    import gsim_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             out_valid,
    output logic [CNT_W-1:0] cnt,
    output logic             in_en,
    output logic             cap_en,
    output logic             load_ok,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("gsim_host_fsm: TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef GSIM_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
`endif

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef GSIM_HOST_TIMEOUT_EN
        tmo_d     = '0;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
`ifdef GSIM_HOST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_SEND: begin
                // Counter wraps 15->0, so WAIT starts at index 0.
                cnt_d = cnt_q + CNT_W'(1);
                if (is_last(cnt_q)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (out_valid) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = is_last(cnt_q) ? ST_DONE : ST_COLLECT;
                end
`ifdef GSIM_HOST_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_COLLECT: begin
                if (out_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last(cnt_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef GSIM_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        in_en   = (state_q == ST_SEND);
        busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done    = (state_q == ST_DONE);
        load_ok = !busy;
        cap_en  = out_valid && ((state_q == ST_WAIT) || (state_q == ST_COLLECT));
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/gsim_host.sv
// Host for a 16-word solver: streams the b buffer out, then captures 16 results into a readable buffer.
// Optional WAIT timeout is enabled by defining GSIM_HOST_TIMEOUT_EN.
module gsim_host
    import gsim_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_en,
    input  logic [3:0]     load_addr,
    input  logic [B_W-1:0] load_data,
    input  logic           start,
    output logic           in_en,
    output logic [B_W-1:0] b_out,
    input  logic           out_valid,
    input  logic [X_W-1:0] x_in,
    input  logic [3:0]     rd_addr,
    output logic [X_W-1:0] rd_data,
    output logic           busy,
    output logic           done,
    output logic           timeout
);

    logic [CNT_W-1:0] cnt;
    logic             cap_en;
    logic             load_ok;

    logic [B_W-1:0] b_mem   [N_WORDS];
    logic [X_W-1:0] res_mem [N_WORDS];

    gsim_host_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .out_valid(out_valid),
        .cnt      (cnt),
        .in_en    (in_en),
        .cap_en   (cap_en),
        .load_ok  (load_ok),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    // NOTE: buffers carry no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            b_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            res_mem[cnt] <= x_in;
        end
    end

    assign b_out   = in_en ? b_mem[cnt] : '0;
    assign rd_data = res_mem[rd_addr];

endmodule

// File: tb/tb_gsim_host.sv
// Directed self-checking bench for gsim_host; timeout scenario follows GSIM_HOST_TIMEOUT_EN.
module tb_gsim_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic        in_en;
    logic [15:0] b_out;
    logic        out_valid;
    logic [31:0] x_in;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    gsim_host #(
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start    (start),
        .in_en    (in_en),
        .b_out    (b_out),
        .out_valid(out_valid),
        .x_in     (x_in),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic skip_send();
        pulse_start();
        repeat (16) tick();
    endtask

    task automatic feed_words(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            out_valid = 1'b1;
            x_in      = base + 32'(i);
            tick();
        end
        out_valid = 1'b0;
        x_in      = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; out_valid = 1'b0; x_in = '0; rd_addr = '0;
        repeat (2) tick();
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL reset_in_en: got %b want 0", in_en); end
        checks++; if (b_out !== 16'h0) begin errors++; $display("FAIL reset_b_out: got %h want 0000", b_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = 16'(i + 1);
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_send();
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL send_idle_in_en: got %b want 0", in_en); end
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (in_en !== 1'b1 || b_out !== 16'(i + 1)) begin
                errors++;
                $display("FAIL send_word%0d: got in_en=%b b_out=%h want 1/%h", i, in_en, b_out, 16'(i + 1));
            end
            tick();
        end
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL send_end_in_en: got %b want 0", in_en); end
        checks++; if (b_out !== 16'h0) begin errors++; $display("FAIL send_end_b_out: got %h want 0000", b_out); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL send_end_wait: got busy=%b done=%b want 1/0", busy, done); end
    endtask

    task automatic test_collect();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL collect_early_done: got %b want 0", done); end
            end
            out_valid = 1'b1;
            x_in      = 32'h100 + 32'(i);
            tick();
        end
        out_valid = 1'b0;
        x_in      = '0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL collect_done: got done=%b busy=%b want 1/0", done, busy); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== 32'h105) begin errors++; $display("FAIL collect_rd5: got %h want 00000105", rd_data); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 32'h100) begin errors++; $display("FAIL collect_rd0: got %h want 00000100", rd_data); end
        rd_addr = 4'd15; #1;
        checks++; if (rd_data !== 32'h10F) begin errors++; $display("FAIL collect_rd15: got %h want 0000010f", rd_data); end
    endtask

    task automatic test_gap();
        skip_send();
        for (int i = 0; i < 8; i++) begin
            out_valid = 1'b1;
            x_in      = 32'h200 + 32'(i);
            tick();
        end
        out_valid = 1'b0;
        x_in      = 32'hDEAD_0000;
        repeat (3) tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL gap_hold: got busy=%b done=%b want 1/0", busy, done); end
        for (int i = 8; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_early_done: got %b want 0", done); end
            end
            out_valid = 1'b1;
            x_in      = 32'h200 + 32'(i);
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", done); end
        out_valid = 1'b1;
        x_in      = 32'h0000_BEEF;
        tick();
        out_valid = 1'b0;
        x_in      = '0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_extra_done: got %b want 1", done); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 32'h200) begin errors++; $display("FAIL gap_rd0: got %h want 00000200", rd_data); end
        rd_addr = 4'd7; #1;
        checks++; if (rd_data !== 32'h207) begin errors++; $display("FAIL gap_rd7: got %h want 00000207", rd_data); end
        rd_addr = 4'd8; #1;
        checks++; if (rd_data !== 32'h208) begin errors++; $display("FAIL gap_rd8: got %h want 00000208", rd_data); end
        rd_addr = 4'd15; #1;
        checks++; if (rd_data !== 32'h20F) begin errors++; $display("FAIL gap_rd15: got %h want 0000020f", rd_data); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = 4'd10;
                load_data = 16'hAAAA;
            end
            checks++;
            if (in_en !== 1'b1 || b_out !== 16'(i + 1)) begin
                errors++;
                $display("FAIL b2b_word%0d: got in_en=%b b_out=%h want 1/%h", i, in_en, b_out, 16'(i + 1));
            end
            tick();
            start   = 1'b0;
            load_en = 1'b0;
        end
        checks++; if (in_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_no_restart: got in_en=%b busy=%b want 0/1", in_en, busy); end
        feed_words(32'h300);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        logic saw_activity;
        pulse_start();
        repeat (7) tick();
        checks++; if (in_en !== 1'b1 || b_out !== 16'd8) begin errors++; $display("FAIL rst_mid_word7: got in_en=%b b_out=%h want 1/0008", in_en, b_out); end
        reset = 1'b0;
        #1;
        checks++; if (in_en !== 1'b0 || b_out !== 16'h0) begin errors++; $display("FAIL rst_mid_in_en: got in_en=%b b_out=%h want 0/0000", in_en, b_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        repeat (2) tick();
        reset = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_en !== 1'b0 || busy !== 1'b0) saw_activity = 1'b1;
        end
        checks++; if (saw_activity !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got activity=%b want 0", saw_activity); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
    endtask

    task automatic test_timeout();
        skip_send();
`ifdef GSIM_HOST_TIMEOUT_EN
        repeat (19) tick();
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: got timeout=%b busy=%b want 0/1", timeout, busy); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b want 1", timeout); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_en !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy=%b done=%b in_en=%b want 0/0/0", busy, done, in_en); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout); end
        pulse_start();
        checks++; if (timeout !== 1'b0 || in_en !== 1'b1) begin errors++; $display("FAIL tmo_clear: got timeout=%b in_en=%b want 0/1", timeout, in_en); end
        repeat (16) tick();
        feed_words(32'h400);
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_rerun_done: got done=%b timeout=%b want 1/0", done, timeout); end
`else
        repeat (25) tick();
        checks++; if (timeout !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL no_tmo_wait: got timeout=%b busy=%b done=%b want 0/1/0", timeout, busy, done); end
        feed_words(32'h400);
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL no_tmo_done: got done=%b timeout=%b want 1/0", done, timeout); end
        rd_addr = 4'd9; #1;
        checks++; if (rd_data !== 32'h409) begin errors++; $display("FAIL no_tmo_rd9: got %h want 00000409", rd_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_send();
        test_collect();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
